// File: rtl/clk_duty_monitor.sv
// Measures period and high-time of a clk-synchronous divided strobe, window by window,
// and flags out-of-tolerance windows or missing rising edges with sticky error bits.
//   state   | meaning
//   IDLE    | monitor off, counters held at zero
//   SYNC    | waiting for the first rise; the partial window is discarded
//   MEAS    | counting a rise-to-rise window
module clk_duty_monitor #(
  parameter int CW      = 8,
  parameter int TOL     = 0,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          div_in,
  input  logic          enable,
  input  logic [CW-1:0] exp_period,
  input  logic [CW-1:0] exp_high,
  input  logic          clr_err,
  output logic [CW-1:0] meas_period,
  output logic [CW-1:0] meas_high,
  output logic          meas_valid,
  output logic          period_err,
  output logic          duty_err,
  output logic          timeout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;

  // The cycle that would bring the count to TIMEOUT is the one that fires the timeout.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW:0]   TOL_C   = (CW+1)'(TOL);

  logic [1:0]    state_q, state_d;
  logic          d_q;
  logic [CW-1:0] per_cnt_q, per_cnt_d;
  logic [CW-1:0] hi_cnt_q, hi_cnt_d;
  logic [CW-1:0] meas_period_q, meas_period_d;
  logic [CW-1:0] meas_high_q, meas_high_d;
  logic          meas_valid_q, meas_valid_d;
  logic          period_err_q, period_err_d;
  logic          duty_err_q, duty_err_d;
  logic          timeout_q, timeout_d;
  logic          per_set, duty_set, to_set;
  logic          rise;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [CW:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] ax, bx;
    ax = {1'b0, a};
    bx = {1'b0, b};
    return (ax >= bx) ? (ax - bx) : (bx - ax);
  endfunction

  assign rise = div_in & ~d_q;

  always_comb begin
    state_d       = state_q;
    per_cnt_d     = per_cnt_q;
    hi_cnt_d      = hi_cnt_q;
    meas_period_d = meas_period_q;
    meas_high_d   = meas_high_q;
    meas_valid_d  = 1'b0;
    per_set       = 1'b0;
    duty_set      = 1'b0;
    to_set        = 1'b0;

    if (!enable) begin
      state_d   = ST_IDLE;
      per_cnt_d = '0;
      hi_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_SYNC;
          per_cnt_d = '0;
          hi_cnt_d  = '0;
        end
        ST_SYNC: begin
          hi_cnt_d = '0;
          if (rise) begin
            state_d   = ST_MEAS;
            per_cnt_d = CW'(1);
            hi_cnt_d  = CW'(1);
          end else if (per_cnt_q >= TO_LAST) begin
            to_set    = 1'b1;
            per_cnt_d = '0;
          end else begin
            per_cnt_d = sat_inc(per_cnt_q);
          end
        end
        ST_MEAS: begin
          if (rise) begin
            meas_period_d = per_cnt_q;
            meas_high_d   = hi_cnt_q;
            meas_valid_d  = 1'b1;
            per_set       = abs_diff(per_cnt_q, exp_period) > TOL_C;
            duty_set      = abs_diff(hi_cnt_q, exp_high) > TOL_C;
            per_cnt_d     = CW'(1);
            hi_cnt_d      = CW'(1);
          end else if (per_cnt_q >= TO_LAST) begin
            to_set    = 1'b1;
            state_d   = ST_SYNC;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
          end else begin
            per_cnt_d = sat_inc(per_cnt_q);
            hi_cnt_d  = div_in ? sat_inc(hi_cnt_q) : hi_cnt_q;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          per_cnt_d = '0;
          hi_cnt_d  = '0;
        end
      endcase
    end

    // A set event in the same cycle as clr_err keeps the flag high.
    period_err_d = per_set  | (period_err_q & ~clr_err);
    duty_err_d   = duty_set | (duty_err_q   & ~clr_err);
    timeout_d    = to_set   | (timeout_q    & ~clr_err);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      d_q           <= 1'b0;
      per_cnt_q     <= '0;
      hi_cnt_q      <= '0;
      meas_period_q <= '0;
      meas_high_q   <= '0;
      meas_valid_q  <= 1'b0;
      period_err_q  <= 1'b0;
      duty_err_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      d_q           <= div_in;
      per_cnt_q     <= per_cnt_d;
      hi_cnt_q      <= hi_cnt_d;
      meas_period_q <= meas_period_d;
      meas_high_q   <= meas_high_d;
      meas_valid_q  <= meas_valid_d;
      period_err_q  <= period_err_d;
      duty_err_q    <= duty_err_d;
      timeout_q     <= timeout_d;
    end
  end

  assign meas_period = meas_period_q;
  assign meas_high   = meas_high_q;
  assign meas_valid  = meas_valid_q;
  assign period_err  = period_err_q;
  assign duty_err    = duty_err_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_clk_duty_monitor.sv
// Directed bench for clk_duty_monitor; a second instance with TOL=1 shares all inputs.
module tb_clk_duty_monitor;

  logic       clk;
  logic       resetn;
  logic       div_in;
  logic       enable;
  logic [7:0] exp_period;
  logic [7:0] exp_high;
  logic       clr_err;

  logic [7:0] meas_period, meas_high;
  logic       meas_valid, period_err, duty_err, timeout;
  logic [7:0] t1_meas_period, t1_meas_high;
  logic       t1_meas_valid, t1_period_err, t1_duty_err, t1_timeout;

  int n_vec = 0;
  int n_err = 0;

  int         cyc_idx, n_valid, first_idx, last_idx, min_gap, max_gap;
  logic [7:0] last_p, last_h;
  logic       last_perr, last_derr;

  clk_duty_monitor #(.CW(8), .TOL(0), .TIMEOUT(64)) dut (
    .clk(clk), .resetn(resetn), .div_in(div_in), .enable(enable),
    .exp_period(exp_period), .exp_high(exp_high), .clr_err(clr_err),
    .meas_period(meas_period), .meas_high(meas_high), .meas_valid(meas_valid),
    .period_err(period_err), .duty_err(duty_err), .timeout(timeout)
  );

  clk_duty_monitor #(.CW(8), .TOL(1), .TIMEOUT(64)) dut_t1 (
    .clk(clk), .resetn(resetn), .div_in(div_in), .enable(enable),
    .exp_period(exp_period), .exp_high(exp_high), .clr_err(clr_err),
    .meas_period(t1_meas_period), .meas_high(t1_meas_high), .meas_valid(t1_meas_valid),
    .period_err(t1_period_err), .duty_err(t1_duty_err), .timeout(t1_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_stats();
    cyc_idx   = -1;
    n_valid   = 0;
    first_idx = -1;
    last_idx  = -1;
    min_gap   = 1000;
    max_gap   = 0;
    last_p    = 8'd0;
    last_h    = 8'd0;
    last_perr = 1'b0;
    last_derr = 1'b0;
  endtask

  // One clock: drive div_in, sample after the edge, record any measurement seen.
  task automatic cyc(input logic v);
    div_in = v;
    @(posedge clk);
    #1;
    cyc_idx++;
    if (meas_valid === 1'b1) begin
      n_valid++;
      if (first_idx < 0) first_idx = cyc_idx;
      if (last_idx >= 0) begin
        if (cyc_idx - last_idx < min_gap) min_gap = cyc_idx - last_idx;
        if (cyc_idx - last_idx > max_gap) max_gap = cyc_idx - last_idx;
      end
      last_idx  = cyc_idx;
      last_p    = meas_period;
      last_h    = meas_high;
      last_perr = period_err;
      last_derr = duty_err;
    end
  endtask

  task automatic run_pattern(input int per, input int hi, input int wins);
    for (int i = 0; i < per * wins; i++) cyc((i % per) < hi);
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    enable     = 1'b0;
    clr_err    = 1'b0;
    div_in     = 1'b0;
    exp_period = 8'd10;
    exp_high   = 8'd4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b0; clr_err = 1'b0; div_in = 1'b0;
    exp_period = 8'd10; exp_high = 8'd4;
    #1;
    n_vec++; if (meas_period !== 8'd0) begin n_err++; $display("FAIL reset_meas_period: got %0d want 0", meas_period); end
    n_vec++; if (meas_high !== 8'd0) begin n_err++; $display("FAIL reset_meas_high: got %0d want 0", meas_high); end
    n_vec++; if ({meas_valid, period_err, duty_err, timeout} !== 4'b0) begin n_err++;
      $display("FAIL reset_flags: got %b want 0000", {meas_valid, period_err, duty_err, timeout}); end
    do_reset();
  endtask

  task automatic test_divider();
    do_reset();
    enable = 1'b1;
    cyc(1'b0);
    clear_stats();
    run_pattern(10, 4, 4);
    n_vec++; if (n_valid !== 3) begin n_err++; $display("FAIL div_n_valid: got %0d want 3", n_valid); end
    n_vec++; if (first_idx !== 10) begin n_err++; $display("FAIL div_first_valid: got %0d want 10", first_idx); end
    n_vec++; if (min_gap !== 10 || max_gap !== 10) begin n_err++;
      $display("FAIL div_gap: got %0d..%0d want 10..10", min_gap, max_gap); end
    n_vec++; if (last_p !== 8'd10) begin n_err++; $display("FAIL div_meas_period: got %0d want 10", last_p); end
    n_vec++; if (last_h !== 8'd4) begin n_err++; $display("FAIL div_meas_high: got %0d want 4", last_h); end
    n_vec++; if ({period_err, duty_err, timeout} !== 3'b000) begin n_err++;
      $display("FAIL div_flags: got %b want 000", {period_err, duty_err, timeout}); end
    n_vec++; if ({t1_period_err, t1_duty_err} !== 2'b00) begin n_err++;
      $display("FAIL div_t1_flags: got %b want 00", {t1_period_err, t1_duty_err}); end
  endtask

  task automatic test_short_period();
    do_reset();
    exp_period = 8'd8; exp_high = 8'd3;
    enable = 1'b1;
    cyc(1'b0);
    clear_stats();
    run_pattern(8, 3, 4);
    n_vec++; if (n_valid !== 3) begin n_err++; $display("FAIL p8_n_valid: got %0d want 3", n_valid); end
    n_vec++; if (min_gap !== 8 || max_gap !== 8) begin n_err++;
      $display("FAIL p8_gap: got %0d..%0d want 8..8", min_gap, max_gap); end
    n_vec++; if (last_p !== 8'd8 || last_h !== 8'd3) begin n_err++;
      $display("FAIL p8_meas: got %0d/%0d want 8/3", last_p, last_h); end
    n_vec++; if ({period_err, duty_err, timeout} !== 3'b000) begin n_err++;
      $display("FAIL p8_flags: got %b want 000", {period_err, duty_err, timeout}); end
  endtask

  task automatic test_duty_55();
    do_reset();
    enable = 1'b1;
    cyc(1'b0);
    clear_stats();
    run_pattern(10, 5, 2);
    n_vec++; if (n_valid !== 1) begin n_err++; $display("FAIL d55_n_valid: got %0d want 1", n_valid); end
    n_vec++; if (last_p !== 8'd10 || last_h !== 8'd5) begin n_err++;
      $display("FAIL d55_meas: got %0d/%0d want 10/5", last_p, last_h); end
    n_vec++; if (last_derr !== 1'b1 || last_perr !== 1'b0) begin n_err++;
      $display("FAIL d55_err_at_valid: got duty=%0d per=%0d want duty=1 per=0", last_derr, last_perr); end
    n_vec++; if ({t1_period_err, t1_duty_err} !== 2'b00) begin n_err++;
      $display("FAIL d55_tol1_flags: got %b want 00", {t1_period_err, t1_duty_err}); end
  endtask

  task automatic test_timeout();
    do_reset();
    enable = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    clear_stats();
    for (int k = 1; k <= 70; k++) begin
      cyc(1'b0);
      if (k == 62) begin
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL to_early: got %0d want 0 at count 63", timeout); end
      end
      if (k == 63) begin
        n_vec++; if (timeout !== 1'b1) begin n_err++; $display("FAIL to_at_64: got %0d want 1 at count 64", timeout); end
      end
    end
    n_vec++; if (n_valid !== 0) begin n_err++; $display("FAIL to_no_valid: got %0d want 0", n_valid); end
    clear_stats();
    run_pattern(10, 4, 3);
    n_vec++; if (n_valid !== 2 || first_idx !== 10) begin n_err++;
      $display("FAIL to_resume: got n=%0d first=%0d want n=2 first=10", n_valid, first_idx); end
    n_vec++; if (last_p !== 8'd10 || last_h !== 8'd4) begin n_err++;
      $display("FAIL to_resume_meas: got %0d/%0d want 10/4", last_p, last_h); end
    n_vec++; if (timeout !== 1'b1 || period_err !== 1'b0) begin n_err++;
      $display("FAIL to_sticky: got to=%0d per=%0d want to=1 per=0", timeout, period_err); end
  endtask

  task automatic test_const_high();
    do_reset();
    enable = 1'b1;
    cyc(1'b1);
    clear_stats();
    for (int k = 1; k <= 64; k++) begin
      cyc(1'b1);
      if (k == 63) begin
        n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL hi_to_early: got %0d want 0", timeout); end
      end
    end
    n_vec++; if (timeout !== 1'b1) begin n_err++; $display("FAIL hi_to: got %0d want 1", timeout); end
    n_vec++; if (n_valid !== 0) begin n_err++; $display("FAIL hi_no_valid: got %0d want 0", n_valid); end
  endtask

  task automatic test_clr_same_cycle();
    do_reset();
    enable = 1'b1;
    cyc(1'b0);
    clear_stats();
    run_pattern(10, 4, 1);
    for (int j = 0; j < 9; j++) cyc(j < 4);
    n_vec++; if (last_p !== 8'd10 || period_err !== 1'b0) begin n_err++;
      $display("FAIL clr_pre: got %0d err=%0d want 10 err=0", last_p, period_err); end
    clr_err = 1'b1;
    cyc(1'b1);
    n_vec++; if (meas_valid !== 1'b1 || meas_period !== 8'd9) begin n_err++;
      $display("FAIL clr_p9_meas: got v=%0d p=%0d want v=1 p=9", meas_valid, meas_period); end
    n_vec++; if (period_err !== 1'b1 || duty_err !== 1'b0) begin n_err++;
      $display("FAIL clr_set_wins: got per=%0d duty=%0d want per=1 duty=0", period_err, duty_err); end
    n_vec++; if (t1_period_err !== 1'b0) begin n_err++; $display("FAIL clr_tol1_p9: got %0d want 0", t1_period_err); end
    cyc(1'b1);
    clr_err = 1'b0;
    n_vec++; if ({period_err, duty_err, timeout} !== 3'b000) begin n_err++;
      $display("FAIL clr_alone: got %b want 000", {period_err, duty_err, timeout}); end
    n_vec++; if (meas_period !== 8'd9) begin n_err++; $display("FAIL clr_meas_hold: got %0d want 9", meas_period); end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1'b1;
    cyc(1'b0);
    clear_stats();
    run_pattern(10, 5, 1);
    cyc(1'b1);
    repeat (4) cyc(1'b1);
    cyc(1'b0);
    n_vec++; if (duty_err !== 1'b1 || meas_period !== 8'd10) begin n_err++;
      $display("FAIL ar_pre: got duty=%0d p=%0d want duty=1 p=10", duty_err, meas_period); end
    #3;
    resetn = 1'b0;
    div_in = 1'b0;
    #2;
    n_vec++; if (meas_period !== 8'd0 || meas_high !== 8'd0) begin n_err++;
      $display("FAIL ar_meas_zero: got %0d/%0d want 0/0", meas_period, meas_high); end
    n_vec++; if ({meas_valid, period_err, duty_err, timeout} !== 4'b0) begin n_err++;
      $display("FAIL ar_flags_zero: got %b want 0000", {meas_valid, period_err, duty_err, timeout}); end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    clear_stats();
    run_pattern(10, 4, 3);
    n_vec++; if (n_valid !== 2 || first_idx !== 10) begin n_err++;
      $display("FAIL ar_two_rises: got n=%0d first=%0d want n=2 first=10", n_valid, first_idx); end
    n_vec++; if (last_p !== 8'd10 || duty_err !== 1'b0) begin n_err++;
      $display("FAIL ar_after: got p=%0d duty=%0d want p=10 duty=0", last_p, duty_err); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    enable = 1'b1;
    cyc(1'b0);
    clear_stats();
    run_pattern(10, 4, 3);
    cyc(1'b1);
    repeat (3) cyc(1'b1);
    cyc(1'b0);
    clear_stats();
    enable = 1'b0;
    repeat (3) cyc(1'b0);
    n_vec++; if (n_valid !== 0) begin n_err++; $display("FAIL en_no_valid: got %0d want 0", n_valid); end
    n_vec++; if (meas_period !== 8'd10 || meas_high !== 8'd4) begin n_err++;
      $display("FAIL en_hold: got %0d/%0d want 10/4", meas_period, meas_high); end
    enable = 1'b1;
    cyc(1'b0);
    clear_stats();
    run_pattern(10, 4, 3);
    n_vec++; if (n_valid !== 2 || first_idx !== 10) begin n_err++;
      $display("FAIL en_resync: got n=%0d first=%0d want n=2 first=10", n_valid, first_idx); end
    n_vec++; if (last_p !== 8'd10 || last_h !== 8'd4) begin n_err++;
      $display("FAIL en_resume_meas: got %0d/%0d want 10/4", last_p, last_h); end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_divider();
    test_short_period();
    test_duty_55();
    test_timeout();
    test_const_high();
    test_clr_same_cycle();
    test_async_reset();
    test_enable_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
